// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single external memory port (icache, dcache, uncached).
// Fixed priority uncached > dcache > icache; define MEM_ARB_ROUND_ROBIN_EN for round-robin.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  icache_en_i,
   input  logic [3:0]            icache_byte_en_i,
   input  logic [ADDR_WIDTH-1:0] icache_addr_i,
   input  logic [DATA_WIDTH-1:0] icache_wdata_i,
   output logic                  icache_ready_o,
   output logic [DATA_WIDTH-1:0] icache_rdata_o,
   input  logic                  dcache_en_i,
   input  logic [3:0]            dcache_byte_en_i,
   input  logic [ADDR_WIDTH-1:0] dcache_addr_i,
   input  logic [DATA_WIDTH-1:0] dcache_wdata_i,
   output logic                  dcache_ready_o,
   output logic [DATA_WIDTH-1:0] dcache_rdata_o,
   input  logic                  uncached_en_i,
   input  logic [3:0]            uncached_byte_en_i,
   input  logic [ADDR_WIDTH-1:0] uncached_addr_i,
   input  logic [DATA_WIDTH-1:0] uncached_wdata_i,
   output logic                  uncached_ready_o,
   output logic [DATA_WIDTH-1:0] uncached_rdata_o,
   output logic                  mem_en_o,
   output logic [3:0]            mem_byte_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_ready_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic [1:0]            grant_o
);

   localparam logic [1:0] G_NONE = 2'd0;
   localparam logic [1:0] G_IC   = 2'd1;
   localparam logic [1:0] G_DC   = 2'd2;
   localparam logic [1:0] G_UC   = 2'd3;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t     state_q, state_d;
   logic [1:0] winner;
   logic [3:1] req;

   logic [3:0]            sel_byte_en;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   assign req = {uncached_en_i, dcache_en_i, icache_en_i};

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic [1:0] last_q;

   // Search starts at the requester after the last one granted.
   always_comb begin
      winner = G_NONE;
      case (last_q)
         G_UC: begin
            if      (req[1]) winner = G_IC;
            else if (req[2]) winner = G_DC;
            else if (req[3]) winner = G_UC;
         end
         G_DC: begin
            if      (req[3]) winner = G_UC;
            else if (req[1]) winner = G_IC;
            else if (req[2]) winner = G_DC;
         end
         default: begin
            if      (req[2]) winner = G_DC;
            else if (req[3]) winner = G_UC;
            else if (req[1]) winner = G_IC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                   last_q <= G_IC;
      else if (state_q == IDLE && winner != G_NONE) last_q <= winner;
   end
`else
   always_comb begin
      winner = G_NONE;
      if      (req[3]) winner = G_UC;
      else if (req[2]) winner = G_DC;
      else if (req[1]) winner = G_IC;
   end
`endif

   always_comb begin
      sel_byte_en = icache_byte_en_i;
      sel_addr    = icache_addr_i;
      sel_wdata   = icache_wdata_i;
      case (winner)
         G_DC: begin
            sel_byte_en = dcache_byte_en_i;
            sel_addr    = dcache_addr_i;
            sel_wdata   = dcache_wdata_i;
         end
         G_UC: begin
            sel_byte_en = uncached_byte_en_i;
            sel_addr    = uncached_addr_i;
            sel_wdata   = uncached_wdata_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (winner != G_NONE) state_d = REQ;
         REQ:     if (mem_ready_i)      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // All port-facing outputs are registered so the bus sees a stable request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_en_o         <= 1'b0;
         mem_byte_en_o    <= '0;
         mem_addr_o       <= '0;
         mem_wdata_o      <= '0;
         grant_o          <= G_NONE;
         icache_ready_o   <= 1'b0;
         dcache_ready_o   <= 1'b0;
         uncached_ready_o <= 1'b0;
         icache_rdata_o   <= '0;
         dcache_rdata_o   <= '0;
         uncached_rdata_o <= '0;
      end else begin
         icache_ready_o   <= 1'b0;
         dcache_ready_o   <= 1'b0;
         uncached_ready_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (winner != G_NONE) begin
                  mem_en_o      <= 1'b1;
                  mem_byte_en_o <= sel_byte_en;
                  mem_addr_o    <= sel_addr;
                  mem_wdata_o   <= sel_wdata;
                  grant_o       <= winner;
               end
            end
            REQ: begin
               if (mem_ready_i) begin
                  mem_en_o <= 1'b0;
                  case (grant_o)
                     G_IC: begin
                        icache_ready_o <= 1'b1;
                        icache_rdata_o <= mem_rdata_i;
                     end
                     G_DC: begin
                        dcache_ready_o <= 1'b1;
                        dcache_rdata_o <= mem_rdata_i;
                     end
                     G_UC: begin
                        uncached_ready_o <= 1'b1;
                        uncached_rdata_o <= mem_rdata_i;
                     end
                     default: ;
                  endcase
               end
            end
            RESP:    grant_o <= G_NONE;
            default: ;
         endcase
      end
   end

endmodule
